fib_seq_engine: RTL

- Parametrised successor to the fixed 8-bit-index / 32-bit Fibonacci block.
- Computes the n-th term of a two-seed additive recurrence, x[i+2] = x[i] + x[i+1]. Seeds come from Fibonacci, Lucas or user-supplied values.
- Uses a start/busy/done handshake, an abort input, and error/overflow status.
- Sits behind the Wishbone-mapped user area. It is clocked from the bus clock and driven by register fields.

---
 rtl/fib_pkg.sv | 20 ++
 rtl/fib_datapath.sv | 67 ++++++
 rtl/fib_seq_engine.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared types and constants for fib_seq_engine (FIB_OVF_EN selects overflow tracking)
package fib_pkg;

  typedef enum logic [1:0] {
    MODE_FIB    = 2'b00,
    MODE_LUCAS  = 2'b01,
    MODE_CUSTOM = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int LUCAS_X0 = 2;
  localparam int LUCAS_X1 = 1;

endpackage

// File: rtl/fib_datapath.sv
// rtl/fib_datapath.sv - term registers, adder, carry flags (FIB_OVF_EN) and index down-counter
module fib_datapath #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] x1,
  input  logic [IDX_W-1:0]  n,
  output logic [DATA_W-1:0] a,
  output logic              a_flag,
  output logic              cnt_zero
);

  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] sum;
  logic [IDX_W-1:0]  cnt;

  assign cnt_zero = (cnt == '0);

`ifdef FIB_OVF_EN
  logic carry;
  logic a_flag_q;
  logic b_flag_q;

  assign {carry, sum} = {1'b0, a} + {1'b0, b};
  assign a_flag = a_flag_q;

  // Flags mark a register whose exact term no longer fits in DATA_W bits; once set they stay set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_flag_q <= 1'b0;
      b_flag_q <= 1'b0;
    end else if (load) begin
      a_flag_q <= 1'b0;
      b_flag_q <= 1'b0;
    end else if (step && !cnt_zero) begin
      a_flag_q <= b_flag_q;
      b_flag_q <= a_flag_q | b_flag_q | carry;
    end
  end
`else
  assign sum    = a + b;
  assign a_flag = 1'b0;
`endif

  // Slide the two-term window forward one index per step; counter stops at zero and never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a   <= '0;
      b   <= '0;
      cnt <= '0;
    end else if (load) begin
      a   <= x0;
      b   <= x1;
      cnt <= n;
    end else if (step && !cnt_zero) begin
      a   <= b;
      b   <= sum;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/fib_seq_engine.sv
// rtl/fib_seq_engine.sv - n-th term of a two-seed additive recurrence with start/busy/done (FIB_OVF_EN enables ovf)
module fib_seq_engine
  import fib_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [IDX_W-1:0]  n,
  input  logic [DATA_W-1:0] seed0,
  input  logic [DATA_W-1:0] seed1,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ovf,
  output logic [DATA_W-1:0] result
);

  state_t            state;
  state_t            state_nxt;
  mode_t             mode_sel;
  logic              load;
  logic              step;
  logic              finish;
  logic              rsvd_req;
  logic [DATA_W-1:0] x0;
  logic [DATA_W-1:0] x1;
  logic [DATA_W-1:0] a;
  logic              a_flag;
  logic              cnt_zero;

  assign mode_sel = mode_t'(mode);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  // Seed selection; the reserved encoding never loads so its value is irrelevant.
  always_comb begin
    x0 = '0;
    x1 = DATA_W'(1);
    case (mode_sel)
      MODE_LUCAS: begin
        x0 = DATA_W'(LUCAS_X0);
        x1 = DATA_W'(LUCAS_X1);
      end
      MODE_CUSTOM: begin
        x0 = seed0;
        x1 = seed1;
      end
      default: ;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath strobes; abort outranks completion in RUN.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    rsvd_req  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (mode_sel == MODE_RSVD) begin
            rsvd_req  = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            load      = 1'b1;
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (cnt_zero) begin
          finish    = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          step = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  fib_datapath #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .x0       (x0),
    .x1       (x1),
    .n        (n),
    .a        (a),
    .a_flag   (a_flag),
    .cnt_zero (cnt_zero)
  );

  // Result and status update only when an operation completes; abort leaves them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      err    <= 1'b0;
    end else if (rsvd_req) begin
      err <= 1'b1;
    end else if (finish) begin
      result <= a;
      err    <= 1'b0;
    end
  end

`ifdef FIB_OVF_EN
  // Overflow status reflects only the returned term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ovf <= 1'b0;
    else if (finish) ovf <= a_flag;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
